// File: rtl/vm_change_dispenser.sv
// Vending-machine change dispenser: greedy quarter/dime/nickel payout
// with coin inventory tracking and refill from the accepted-coin pulses.
module vm_change_dispenser #(
    parameter int AMT_W   = 9,
    parameter int CNT_W   = 8,
    parameter int INIT_Q  = 4,
    parameter int INIT_D  = 4,
    parameter int INIT_N  = 4,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_valid,
    input  logic [AMT_W-1:0] chg_amount,
    output logic             chg_ready,
    input  logic             coin_in_q,
    input  logic             coin_in_d,
    input  logic             coin_in_n,
    output logic             quarter_out,
    output logic             dime_out,
    output logic             nickel_out,
    output logic             done,
    output logic             insufficient,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] q_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] n_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        EJECT,
        GAP,
        FIN,
        FAIL
    } state_t;

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [AMT_W-1:0] Q_VAL = AMT_W'(25);
    localparam logic [AMT_W-1:0] D_VAL = AMT_W'(10);
    localparam logic [AMT_W-1:0] N_VAL = AMT_W'(5);

    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t        state;
    logic [GW-1:0] gap_cnt;

    logic take_fin;
    logic take_q;
    logic take_d;
    logic take_n;
    logic dec_q;
    logic dec_d;
    logic dec_n;

    // Greedy choice, made mutually exclusive so the FSM can decode it flat.
    always_comb begin
        take_fin = 1'b0;
        take_q   = 1'b0;
        take_d   = 1'b0;
        take_n   = 1'b0;
        if (remaining == '0) begin
            take_fin = 1'b1;
        end else if (remaining >= Q_VAL && q_cnt != '0) begin
            take_q = 1'b1;
        end else if (remaining >= D_VAL && d_cnt != '0) begin
            take_d = 1'b1;
        end else if (remaining >= N_VAL && n_cnt != '0) begin
            take_n = 1'b1;
        end
    end

    assign dec_q = (state == PICK) && take_q;
    assign dec_d = (state == PICK) && take_d;
    assign dec_n = (state == PICK) && take_n;

    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] r;
        r = cnt;
        if (inc && !dec) begin
            if (cnt != CNT_MAX) begin
                r = cnt + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            r = cnt - CNT_W'(1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt <= CNT_W'(INIT_Q);
            d_cnt <= CNT_W'(INIT_D);
            n_cnt <= CNT_W'(INIT_N);
        end else begin
            q_cnt <= cnt_next(q_cnt, coin_in_q, dec_q);
            d_cnt <= cnt_next(d_cnt, coin_in_d, dec_d);
            n_cnt <= cnt_next(n_cnt, coin_in_n, dec_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            chg_ready    <= 1'b1;
            quarter_out  <= 1'b0;
            dime_out     <= 1'b0;
            nickel_out   <= 1'b0;
            done         <= 1'b0;
            insufficient <= 1'b0;
            remaining    <= '0;
        end else begin
            quarter_out  <= 1'b0;
            dime_out     <= 1'b0;
            nickel_out   <= 1'b0;
            done         <= 1'b0;
            insufficient <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (chg_valid && chg_ready) begin
                        remaining <= chg_amount;
                        chg_ready <= 1'b0;
                        state     <= PICK;
                    end
                end
                PICK: begin
                    unique case (1'b1)
                        take_fin: begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                        take_q: begin
                            quarter_out <= 1'b1;
                            remaining   <= remaining - Q_VAL;
                            state       <= EJECT;
                        end
                        take_d: begin
                            dime_out  <= 1'b1;
                            remaining <= remaining - D_VAL;
                            state     <= EJECT;
                        end
                        take_n: begin
                            nickel_out <= 1'b1;
                            remaining  <= remaining - N_VAL;
                            state      <= EJECT;
                        end
                        default: begin
                            insufficient <= 1'b1;
                            state        <= FAIL;
                        end
                    endcase
                end
                EJECT: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= PICK;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                FIN: begin
                    remaining <= '0;
                    chg_ready <= 1'b1;
                    state     <= IDLE;
                end
                FAIL: begin
                    // Unreturned cents stay visible until the next request.
                    chg_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    chg_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
